instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Initiator side of the decoder instruction handshake. Fetches 16-bit words from a
//  synchronous program ROM at the program counter and presents each to the decoder
//  on instruction/IR. It holds the word until the execution FSMs (MOV/ALU/LDSR) return IF,
//  then retires the word and advances the PC. It also handles jumps, halt and a stuck-handshake timeout.
// PARAMETERS
//  ADDR_W      8      program-counter / ROM address width
//  RESET_PC    0      PC value after reset
//  HALT_OP     4'hF   opcode[15:12] that stops fetching (never issued to decoder)
//  IF_TIMEOUT  255    max cycles in ISSUE without IF before error
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       asynchronous, ACTIVE-LOW reset (0 = reset asserted)
//  run          in   1       level; 1 = fetch/issue enabled
//  mem_addr     out  ADDR_W  ROM address (= pc during FETCH)
//  mem_rd       out  1       ROM read strobe; data valid on mem_data one cycle later
//  mem_data     in   16      ROM read data
//  instruction  out  16      word to decoder: [15:12] opcode, [11:6] i, [5:0] j
//  IR           out  1       instruction valid to decoder
//  IF           in   1       instruction finished, from execution FSMs
//  jmp          in   1       with IF: load PC from jmp_addr instead of PC+1
//  jmp_addr     in   ADDR_W  jump target
//  pc           out  ADDR_W  current program counter
//  halted       out  1       sticky; HALT state reached
//  timeout_err  out  1       sticky; IF never arrived within IF_TIMEOUT
// BEHAVIOUR
//  - reset==0 (async, takes effect immediately): state=IDLE, pc=RESET_PC, instruction=0,
//    IR=0, mem_rd=0, mem_addr=0, halted=0, timeout_err=0, timeout counter=0.
//  - States: IDLE, FETCH, WAIT, ISSUE, RETIRE, HALT. All transitions occur on the rising clk edge.
//    IDLE:   run=1 -> FETCH; otherwise stay.
//    FETCH:  mem_rd=1, mem_addr=pc; -> WAIT.
//    WAIT:   mem_rd=0. Capture mem_data. If opcode==HALT_OP -> HALT (instruction and IR unchanged).
//            Otherwise instruction<=mem_data, IR<=1, counter<=0, -> ISSUE.
//    ISSUE:  IR=1, instruction held stable. IF=1 -> RETIRE, IR<=0, and
//            pc<=jmp ? jmp_addr : pc+1 (modulo 2^ADDR_W, wraps max->0).
//            Otherwise counter++; counter==IF_TIMEOUT -> timeout_err<=1, IR<=0, -> HALT.
//    RETIRE: IR=0 for exactly one cycle; run=1 -> FETCH, run=0 -> IDLE.
//    HALT:   halted=1, IR=0; exit only via reset.
//  - IF and jmp are ignored in every state except ISSUE. jmp without IF has no effect.
//  - run falling during FETCH/WAIT/ISSUE does not abort; the current word completes, then IDLE.
//  - Latency: the IR rising edge occurs on the 3rd clk edge after run=1 is sampled in IDLE.
//    Back-to-back issue: from IF sampled to the next IR rise is 4 edges (RETIRE, FETCH, WAIT, ISSUE).
//  - IR is never high in two consecutive instructions without an intervening IR=0 cycle.
//  - The instruction output changes only on the WAIT->ISSUE edge.
// TESTING
//  1 Reset: hold reset=0 with run=1 -> IR=0, pc=0, mem_rd=0, halted=0; after release IR stays 0 for 2 edges.
//  2 ROM[0]=16'h9084 (MOVI R2,#4), ROM[1]=16'hA002 (MOV R0,R2), run=1, IF pulsed 1 cycle
//    after 3 ISSUE cycles -> instruction=9084 then A002, IR drops for RETIRE, pc 0->1->2.
//  3 Jump: in ISSUE at pc=1, IF=1 with jmp=1, jmp_addr=8'h40 -> pc=8'h40, next mem_addr=8'h40.
//    Also pc=8'hFF, IF without jmp -> pc=0.
//  4 Halt: ROM[2]=16'hF000 -> after WAIT, halted=1, IR never rises for it, pc stays 2.
//  5 Timeout: IF held 0 -> timeout_err=1 and IR=0 exactly IF_TIMEOUT cycles into ISSUE; HALT.
//  6 Reset mid-ISSUE: drive reset=0 between edges -> IR and instruction go 0 before the next edge; pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetches 16-bit words from a synchronous program ROM, hands each one to the decoder
// with an IR/IF handshake, and retires it before advancing or jumping the PC.
module instr_fetch_unit #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [3:0]        HALT_OP    = 4'hF,
    parameter int                IF_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_data,
    output logic [15:0]       instruction,
    output logic              IR,
    input  logic              IF,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              timeout_err
);

    // state  | meaning
    // IDLE   | waiting for run
    // FETCH  | ROM read strobe at pc
    // WAIT   | ROM data valid; decode halt or load instruction
    // ISSUE  | IR high, waiting for IF (timeout counter running)
    // RETIRE | one-cycle IR low gap after IF
    // HALT   | stopped until reset
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_RETIRE, S_HALT
    } state_t;

    localparam int CNT_W = $clog2(IF_TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             is_halt_op;
    logic             timeout_hit;

    assign is_halt_op  = (mem_data[15:12] == HALT_OP);
    // The edge that would bring the count to IF_TIMEOUT is the timeout edge.
    assign timeout_hit = (cnt == CNT_W'(IF_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_WAIT;
            S_WAIT:   state_nxt = is_halt_op ? S_HALT : S_ISSUE;
            S_ISSUE: begin
                if (IF)               state_nxt = S_RETIRE;
                else if (timeout_hit) state_nxt = S_HALT;
            end
            S_RETIRE: state_nxt = run ? S_FETCH : S_IDLE;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = '0;
        if (state == S_FETCH) begin
            mem_rd   = 1'b1;
            mem_addr = pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            instruction <= '0;
            IR          <= 1'b0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= '0;
        end else begin
            unique case (state)
                S_WAIT: begin
                    if (is_halt_op) begin
                        halted <= 1'b1;
                    end else begin
                        instruction <= mem_data;
                        IR          <= 1'b1;
                        cnt         <= '0;
                    end
                end
                S_ISSUE: begin
                    if (IF) begin
                        IR <= 1'b0;
                        pc <= jmp ? jmp_addr : pc + ADDR_W'(1);
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                        halted      <= 1'b1;
                        IR          <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a ROM model feeds the DUT, expected issues
// are queued per scenario and checked by a monitor at every IR rise.
module tb_instr_fetch_unit;

    localparam int IF_TIMEOUT = 255;

    typedef struct packed {
        logic [15:0] ins;
        logic [7:0]  pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic [15:0] instruction;
    logic        IR;
    logic        IF;
    logic        jmp;
    logic [7:0]  jmp_addr;
    logic [7:0]  pc;
    logic        halted;
    logic        timeout_err;

    logic [15:0] rom [256];
    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    instr_fetch_unit #(
        .ADDR_W(8), .RESET_PC(8'h00), .HALT_OP(4'hF), .IF_TIMEOUT(IF_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .instruction(instruction), .IR(IR), .IF(IF),
        .jmp(jmp), .jmp_addr(jmp_addr), .pc(pc),
        .halted(halted), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_data <= rom[mem_addr];
    end

    // Issue monitor: every IR rise must match the head of the scoreboard.
    logic        prev_ir = 1'b0;
    logic [15:0] prev_ins = '0;
    always @(negedge clk) begin
        if (IR && !prev_ir) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got ins=%h pc=%h, none expected", instruction, pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (instruction !== e.ins || pc !== e.pc) begin
                    errors++;
                    $display("FAIL issue_word: got ins=%h pc=%h, expected ins=%h pc=%h",
                             instruction, pc, e.ins, e.pc);
                end
            end
        end else if (IR && prev_ir) begin
            checks++;
            if (instruction !== prev_ins) begin
                errors++;
                $display("FAIL ins_stable: got %h, expected %h", instruction, prev_ins);
            end
        end
        prev_ir  = IR;
        prev_ins = instruction;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run = 1'b0; IF = 1'b0; jmp = 1'b0; jmp_addr = '0;
        sb.delete();
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic wait_ir();
        int n = 0;
        while (IR !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (IR !== 1'b1) begin
            errors++;
            $display("FAIL wait_ir: IR=%b after %0d cycles, expected 1", IR, n);
        end
    endtask

    task automatic pulse_if(input logic j, input logic [7:0] a);
        IF = 1'b1; jmp = j; jmp_addr = a;
        tick();
        IF = 1'b0; jmp = 1'b0;
    endtask

    task automatic sb_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_empty: %0d pending, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rom_clear();
        rom[0] = 16'h9084;
        reset = 1'b0; run = 1'b1; IF = 1'b0; jmp = 1'b0; jmp_addr = '0;
        sb.delete();
        tick(); tick(); tick();
        checks++;
        if (IR !== 1'b0 || pc !== 8'h00 || mem_rd !== 1'b0 || halted !== 1'b0 ||
            timeout_err !== 1'b0 || instruction !== 16'h0 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: IR=%b pc=%h rd=%b halted=%b to=%b ins=%h addr=%h, expected all 0",
                     IR, pc, mem_rd, halted, timeout_err, instruction, mem_addr);
        end
        sb.push_back('{ins: 16'h9084, pc: 8'h00});
        reset = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            tick();
            checks++;
            if (IR !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_edge%0d: IR=%b, expected 0", e, IR);
            end
        end
        tick();
        checks++;
        if (IR !== 1'b1 || instruction !== 16'h9084) begin
            errors++;
            $display("FAIL first_issue_latency: IR=%b ins=%h, expected 1 / 9084", IR, instruction);
        end
        tick();
        sb_empty("reset");
    endtask

    task automatic test_back_to_back();
        rom_clear();
        rom[0] = 16'h9084; rom[1] = 16'hA002; rom[2] = 16'hF000;
        do_reset();
        sb.push_back('{ins: 16'h9084, pc: 8'h00});
        sb.push_back('{ins: 16'hA002, pc: 8'h01});
        run = 1'b1;
        wait_ir();
        tick(); tick(); tick();
        checks++;
        if (IR !== 1'b1 || instruction !== 16'h9084 || pc !== 8'h00) begin
            errors++;
            $display("FAIL hold_word0: IR=%b ins=%h pc=%h, expected 1/9084/00", IR, instruction, pc);
        end
        pulse_if(1'b0, 8'h00);
        checks++;
        if (IR !== 1'b0 || pc !== 8'h01) begin
            errors++;
            $display("FAIL retire0: IR=%b pc=%h, expected 0/01", IR, pc);
        end
        tick(); tick();
        checks++;
        if (IR !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early: IR=%b at edge 3, expected 0", IR);
        end
        tick();
        checks++;
        if (IR !== 1'b1 || instruction !== 16'hA002) begin
            errors++;
            $display("FAIL b2b_edge4: IR=%b ins=%h, expected 1/A002", IR, instruction);
        end
        tick(); tick();
        pulse_if(1'b0, 8'h00);
        checks++;
        if (IR !== 1'b0 || pc !== 8'h02) begin
            errors++;
            $display("FAIL retire1: IR=%b pc=%h, expected 0/02", IR, pc);
        end
        tick();
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h02) begin
            errors++;
            $display("FAIL fetch2: rd=%b addr=%h, expected 1/02", mem_rd, mem_addr);
        end
        tick(); tick();
        checks++;
        if (halted !== 1'b1 || IR !== 1'b0 || pc !== 8'h02) begin
            errors++;
            $display("FAIL halt: halted=%b IR=%b pc=%h, expected 1/0/02", halted, IR, pc);
        end
        pulse_if(1'b1, 8'h33);
        repeat (6) tick();
        checks++;
        if (halted !== 1'b1 || IR !== 1'b0 || pc !== 8'h02 || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL halt_sticky: halted=%b IR=%b pc=%h rd=%b, expected 1/0/02/0",
                     halted, IR, pc, mem_rd);
        end
        sb_empty("b2b");
    endtask

    task automatic test_jump();
        rom_clear();
        rom[0] = 16'h9084; rom[1] = 16'hA002; rom[8'h40] = 16'h1234;
        do_reset();
        sb.push_back('{ins: 16'h9084, pc: 8'h00});
        sb.push_back('{ins: 16'hA002, pc: 8'h01});
        sb.push_back('{ins: 16'h1234, pc: 8'h40});
        run = 1'b1;
        wait_ir();
        tick();
        pulse_if(1'b0, 8'h00);
        wait_ir();
        jmp = 1'b1; jmp_addr = 8'h80;
        tick();
        jmp = 1'b0;
        checks++;
        if (pc !== 8'h01 || IR !== 1'b1) begin
            errors++;
            $display("FAIL jmp_without_if: pc=%h IR=%b, expected 01/1", pc, IR);
        end
        pulse_if(1'b1, 8'h40);
        checks++;
        if (pc !== 8'h40) begin
            errors++;
            $display("FAIL jump_pc: pc=%h, expected 40", pc);
        end
        tick();
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h40) begin
            errors++;
            $display("FAIL jump_fetch: rd=%b addr=%h, expected 1/40", mem_rd, mem_addr);
        end
        wait_ir();
        pulse_if(1'b0, 8'h00);
        checks++;
        if (pc !== 8'h41) begin
            errors++;
            $display("FAIL post_jump_inc: pc=%h, expected 41", pc);
        end
        tick(); tick(); tick();
        sb_empty("jump");
    endtask

    task automatic test_wrap_run_drop();
        logic bad;
        rom_clear();
        rom[0] = 16'h9084; rom[8'hFF] = 16'h5555;
        do_reset();
        sb.push_back('{ins: 16'h9084, pc: 8'h00});
        sb.push_back('{ins: 16'h5555, pc: 8'hFF});
        run = 1'b1;
        wait_ir();
        pulse_if(1'b1, 8'hFF);
        wait_ir();
        run = 1'b0;
        tick();
        pulse_if(1'b0, 8'h00);
        checks++;
        if (pc !== 8'h00 || IR !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h IR=%b, expected 00/0", pc, IR);
        end
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (mem_rd !== 1'b0 || IR !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL run_drop_idle: activity=%b halted=%b, expected 0/0", bad, halted);
        end
        sb_empty("wrap");
    endtask

    task automatic test_timeout();
        rom_clear();
        rom[0] = 16'hA002;
        do_reset();
        sb.push_back('{ins: 16'hA002, pc: 8'h00});
        run = 1'b1;
        wait_ir();
        repeat (IF_TIMEOUT - 1) tick();
        checks++;
        if (IR !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: IR=%b to=%b, expected 1/0", IR, timeout_err);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || IR !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hit: to=%b IR=%b halted=%b, expected 1/0/1",
                     timeout_err, IR, halted);
        end
        tick(); tick();
        checks++;
        if (IR !== 1'b0 || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL timeout_halt: IR=%b rd=%b, expected 0/0", IR, mem_rd);
        end
        sb_empty("timeout");
    endtask

    task automatic test_reset_mid_issue();
        rom_clear();
        rom[0] = 16'h9084; rom[1] = 16'hA002;
        do_reset();
        sb.push_back('{ins: 16'h9084, pc: 8'h00});
        sb.push_back('{ins: 16'hA002, pc: 8'h01});
        run = 1'b1;
        wait_ir();
        pulse_if(1'b0, 8'h00);
        wait_ir();
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (IR !== 1'b0 || instruction !== 16'h0 || pc !== 8'h00 || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_issue: IR=%b ins=%h pc=%h rd=%b, expected 0/0000/00/0",
                     IR, instruction, pc, mem_rd);
        end
        run = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        sb_empty("reset_mid");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; run = 1'b0; IF = 1'b0; jmp = 1'b0; jmp_addr = '0;
        test_reset();
        test_back_to_back();
        test_jump();
        test_wrap_run_drop();
        test_timeout();
        test_reset_mid_issue();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
